// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load-type encodings,
// response-FSM states and the packed layouts of the EX->MEM and MEM->WB buses.
package mem_stage_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD = 164;
    localparam int unsigned MS_TO_WS_BUS_WD = 157;
    localparam int unsigned MS_TO_DS_BUS_WD = 39;

    // Load-type encodings carried in the ld_type field.
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;
    localparam logic [2:0] LD_WL = 3'd5;
    localparam logic [2:0] LD_WR = 3'd6;

    // Data-SRAM response tracking.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2,
        StDrop = 2'd3
    } ms_state_e;

    // EX -> MEM payload, MSB first.
    typedef struct packed {
        logic        tlbwi;
        logic        tlbr;
        logic        ex;
        logic [4:0]  exccode;
        logic        bd;
        logic [31:0] badvaddr;
        logic        eret;
        logic        mtc0;
        logic [7:0]  cp0_addr;
        logic [31:0] rt;
        logic        load_op;
        logic [2:0]  ld_type;
        logic [1:0]  addr_lo;
        logic        req_sent;
        logic        res_from_cp0;
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    // MEM -> WB payload, MSB first; load fields dropped, result substituted.
    typedef struct packed {
        logic        tlbwi;
        logic        tlbr;
        logic        ex;
        logic [4:0]  exccode;
        logic        bd;
        logic [31:0] badvaddr;
        logic        eret;
        logic        mtc0;
        logic [7:0]  cp0_addr;
        logic [31:0] cp0_wdata;
        logic        res_from_cp0;
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load-data extraction: selects byte/halfword by address, sign/zero extends,
// and (with MS_UNALIGNED_LD_EN) merges lwl/lwr bytes into rt with a byte mask.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    output logic [31:0] result,
    output logic [3:0]  byte_mask
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

`ifndef MS_UNALIGNED_LD_EN
    // rt only matters for lwl/lwr merging.
    logic unused_rt;
    assign unused_rt = ^rt;
`endif

    // Pick the addressed byte and halfword out of the memory word.
    always_comb begin
        byte_sel = rdata[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend or merge according to the load type.
    always_comb begin
        result    = rdata;
        byte_mask = 4'hf;
        case (ld_type)
            LD_B:  result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU: result = {24'h0, byte_sel};
            LD_H:  result = {{16{half_sel[15]}}, half_sel};
            LD_HU: result = {16'h0, half_sel};
`ifdef MS_UNALIGNED_LD_EN
            LD_WL: begin
                unique case (addr_lo)
                    2'd0: begin result = {rdata[7:0], rt[23:0]};  byte_mask = 4'b1000; end
                    2'd1: begin result = {rdata[15:0], rt[15:0]}; byte_mask = 4'b1100; end
                    2'd2: begin result = {rdata[23:0], rt[7:0]};  byte_mask = 4'b1110; end
                    default: begin result = rdata;                byte_mask = 4'b1111; end
                endcase
            end
            LD_WR: begin
                unique case (addr_lo)
                    2'd1: begin result = {rt[31:24], rdata[31:8]};  byte_mask = 4'b0111; end
                    2'd2: begin result = {rt[31:16], rdata[31:16]}; byte_mask = 4'b0011; end
                    2'd3: begin result = {rt[31:8], rdata[31:24]};  byte_mask = 4'b0001; end
                    default: begin result = rdata;                  byte_mask = 4'b1111; end
                endcase
            end
`endif
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: registers the EX bus, tracks the outstanding data-SRAM response
// (buffering it across WB stalls and discarding it after a WB flush), extends
// load data, and feeds WB, the ID forwarding bus and the EX flush flag.
// Optional: MS_UNALIGNED_LD_EN enables lwl/lwr merging in load_extend.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    output logic                       ms_ex_flush,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ws_cancel
);

    es_to_ms_t es_in;
    es_to_ms_t bus_q, bus_d;
    logic      ms_valid_q, ms_valid_d;
    ms_state_e state_q, state_d;
    logic [31:0] data_buf_q, data_buf_d;

    logic        ms_ready_go;
    logic        need_resp;
    logic        data_ok_wait;
    logic        accept;
    logic        enter_req;
    logic [31:0] mem_word;
    logic [31:0] ld_result;
    logic [3:0]  ld_mask;
    logic [3:0]  rf_we_out;
    logic [31:0] final_result;
    logic        fwd_valid;
    logic        blk;
    ms_to_ws_t   ws_out;

    assign es_in = es_to_ms_bus;

    // Handshake and readiness.
    always_comb begin
        need_resp    = bus_q.req_sent && !bus_q.ex;
        data_ok_wait = (state_q == StWait) && data_sram_data_ok;
        ms_ready_go  = !need_resp || data_ok_wait || (state_q == StHold);
        // DROP blocks new entries so a stale response cannot be claimed.
        ms_allowin   = !reset && (state_q != StDrop)
                       && (!ms_valid_q || (ms_ready_go && ws_allowin));
        ms_to_ws_valid = ms_valid_q && ms_ready_go && !ws_cancel;
        accept       = es_to_ms_valid && ms_allowin;
        enter_req    = accept && !ws_cancel && es_in.req_sent && !es_in.ex;
    end

    // Pipeline valid and bus register next state.
    always_comb begin
        ms_valid_d = ms_valid_q;
        if (ws_cancel) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        bus_d = accept ? es_in : bus_q;
    end

    // Response FSM next state and response buffer.
    always_comb begin
        state_d    = state_q;
        data_buf_d = data_buf_q;
        unique case (state_q)
            StIdle: begin
                if (enter_req) state_d = StWait;
            end
            StWait: begin
                if (ws_cancel) begin
                    state_d = data_sram_data_ok ? StIdle : StDrop;
                end else if (data_sram_data_ok) begin
                    if (ws_allowin) begin
                        state_d = enter_req ? StWait : StIdle;
                    end else begin
                        state_d    = StHold;
                        data_buf_d = data_sram_rdata;
                    end
                end
            end
            StHold: begin
                if (ws_cancel) begin
                    state_d = StIdle;
                end else if (ws_allowin) begin
                    state_d = enter_req ? StWait : StIdle;
                end
            end
            StDrop: begin
                if (data_sram_data_ok) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            bus_q      <= '0;
            state_q    <= StIdle;
            data_buf_q <= 32'h0;
        end else begin
            ms_valid_q <= ms_valid_d;
            bus_q      <= bus_d;
            state_q    <= state_d;
            data_buf_q <= data_buf_d;
        end
    end

    assign mem_word = (state_q == StHold) ? data_buf_q : data_sram_rdata;

    load_extend u_load_extend (
        .ld_type   (bus_q.ld_type),
        .addr_lo   (bus_q.addr_lo),
        .rdata     (mem_word),
        .rt        (bus_q.rt),
        .result    (ld_result),
        .byte_mask (ld_mask)
    );

    // Output buses.
    always_comb begin
        final_result = bus_q.load_op ? ld_result : bus_q.alu_result;
        rf_we_out    = bus_q.rf_we & (bus_q.load_op ? ld_mask : 4'hf);
        fwd_valid    = ms_valid_q && (|rf_we_out);
        blk          = ms_valid_q && (bus_q.res_from_cp0 || (bus_q.load_op && !ms_ready_go));

        ws_out.tlbwi        = bus_q.tlbwi;
        ws_out.tlbr         = bus_q.tlbr;
        ws_out.ex           = bus_q.ex;
        ws_out.exccode      = bus_q.exccode;
        ws_out.bd           = bus_q.bd;
        ws_out.badvaddr     = bus_q.badvaddr;
        ws_out.eret         = bus_q.eret;
        ws_out.mtc0         = bus_q.mtc0;
        ws_out.cp0_addr     = bus_q.cp0_addr;
        ws_out.cp0_wdata    = bus_q.rt;
        ws_out.res_from_cp0 = bus_q.res_from_cp0;
        ws_out.rf_we        = rf_we_out;
        ws_out.dest         = bus_q.dest;
        ws_out.final_result = final_result;
        ws_out.pc           = bus_q.pc;

        ms_to_ws_bus = ws_out;
        ms_to_ds_bus = {fwd_valid, blk, bus_q.dest, final_result};
        ms_ex_flush  = ms_valid_q && (bus_q.ex || bus_q.eret);
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [163:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [156:0] ms_to_ws_bus;
    logic [38:0]  ms_to_ds_bus;
    logic         ms_ex_flush;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_cancel;

    int n_checks = 0;
    int n_errors = 0;
    int hs_count = 0;
    int hs_base;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus),
        .ms_ex_flush       (ms_ex_flush),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_cancel         (ws_cancel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count MEM->WB handshakes away from the active edge.
    always @(negedge clk) begin
        if (ms_to_ws_valid && ws_allowin) hs_count <= hs_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [163:0] mk_bus(
        input logic        ex,
        input logic [4:0]  exccode,
        input logic [31:0] rt,
        input logic        load_op,
        input logic [2:0]  ld_type,
        input logic [1:0]  addr_lo,
        input logic        req_sent,
        input logic [3:0]  rf_we,
        input logic [4:0]  dest,
        input logic [31:0] alu,
        input logic [31:0] pc
    );
        return {1'b0, 1'b0, ex, exccode, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0, rt,
                load_op, ld_type, addr_lo, req_sent,
                1'b0, rf_we, dest, alu, pc};
    endfunction

    // Load with a request already sent by EX.
    function automatic logic [163:0] mk_load(input logic [2:0] ld_type,
                                             input logic [1:0] addr_lo,
                                             input logic [31:0] rt);
        return mk_bus(1'b0, 5'h0, rt, 1'b1, ld_type, addr_lo, 1'b1, 4'hf, 5'd7,
                      {30'h0400_0000, addr_lo}, 32'hbfc0_0100);
    endfunction

    initial begin
        reset             = 1'b1;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        ws_cancel         = 1'b0;

        // Reset: everything driven low.
        tick();
        tick();
        chk("rst_allowin", 32'(ms_allowin), 32'h0);
        chk("rst_ws_valid", 32'(ms_to_ws_valid), 32'h0);
        chk("rst_ws_bus", 32'(|ms_to_ws_bus), 32'h0);
        chk("rst_ds_bus", 32'(|ms_to_ds_bus), 32'h0);
        chk("rst_ex_flush", 32'(ms_ex_flush), 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_allowin", 32'(ms_allowin), 32'h1);

        // lb addr_lo=2, response with WB ready: passes through same cycle.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_load(3'd1, 2'd2, 32'h0);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("lb_wait_valid", 32'(ms_to_ws_valid), 32'h0);
        chk("lb_wait_blk", 32'(ms_to_ds_bus[37]), 32'h1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1280_3456;
        #1;
        chk("lb_valid", 32'(ms_to_ws_valid), 32'h1);
        chk("lb_result", ms_to_ws_bus[63:32], 32'hffff_ff80);
        chk("lb_rf_we", 32'(ms_to_ws_bus[72:69]), 32'hf);
        chk("lb_fwd", 32'(ms_to_ds_bus[38:37]), 32'h2);
        chk("lb_fwd_result", ms_to_ds_bus[31:0], 32'hffff_ff80);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk("lb_done_valid", 32'(ms_to_ws_valid), 32'h0);

        // lhu with WB stalled: response held, delivered once on release.
        hs_base        = hs_count;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_load(3'd4, 2'd0, 32'h0);
        tick();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hdead_beef;
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk("lhu_hold_allowin", 32'(ms_allowin), 32'h0);
        chk("lhu_hold_valid", 32'(ms_to_ws_valid), 32'h1);
        chk("lhu_hold_result", ms_to_ws_bus[63:32], 32'h0000_beef);
        tick();
        tick();
        ws_allowin = 1'b1;
        #1;
        chk("lhu_rel_allowin", 32'(ms_allowin), 32'h1);
        chk("lhu_rel_result", ms_to_ws_bus[63:32], 32'h0000_beef);
        tick();
        chk("lhu_after_valid", 32'(ms_to_ws_valid), 32'h0);
        chk("lhu_once", 32'(hs_count - hs_base), 32'h1);

        // Cancel in WAIT: late response dropped, next load gets its own data.
        hs_base        = hs_count;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_load(3'd0, 2'd0, 32'h0);
        tick();
        es_to_ms_valid = 1'b0;
        ws_cancel      = 1'b1;
        #1;
        chk("cancel_valid", 32'(ms_to_ws_valid), 32'h0);
        tick();
        ws_cancel = 1'b0;
        #1;
        chk("drop_allowin", 32'(ms_allowin), 32'h0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk_load(3'd0, 2'd0, 32'h0);
        #1;
        chk("drop_ok_valid", 32'(ms_to_ws_valid), 32'h0);
        chk("drop_ok_allowin", 32'(ms_allowin), 32'h0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        chk("drop_exit_allowin", 32'(ms_allowin), 32'h1);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h2222_2222;
        #1;
        chk("after_drop_valid", 32'(ms_to_ws_valid), 32'h1);
        chk("after_drop_result", ms_to_ws_bus[63:32], 32'h2222_2222);
        tick();
        data_sram_data_ok = 1'b0;
        chk("drop_deliveries", 32'(hs_count - hs_base), 32'h1);

        // Cancel and response together: back to IDLE, no DROP stall.
        hs_base        = hs_count;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_load(3'd0, 2'd0, 32'h0);
        tick();
        es_to_ms_valid    = 1'b0;
        ws_cancel         = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h3333_3333;
        #1;
        chk("same_cyc_valid", 32'(ms_to_ws_valid), 32'h0);
        tick();
        ws_cancel         = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        chk("same_cyc_allowin", 32'(ms_allowin), 32'h1);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_load(3'd0, 2'd0, 32'h0);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h4444_4444;
        #1;
        chk("same_cyc_next_result", ms_to_ws_bus[63:32], 32'h4444_4444);
        tick();
        data_sram_data_ok = 1'b0;
        chk("same_cyc_deliveries", 32'(hs_count - hs_base), 32'h1);

        // Exception with no request: ready at once, flush flag raised.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(1'b1, 5'h0c, 32'h0, 1'b0, 3'd0, 2'd0, 1'b0, 4'h0, 5'd0,
                                32'h1234_5678, 32'hbfc0_0200);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("ex_valid", 32'(ms_to_ws_valid), 32'h1);
        chk("ex_flush", 32'(ms_ex_flush), 32'h1);
        chk("ex_exccode", 32'(ms_to_ws_bus[153:149]), 32'h0c);
        chk("ex_bit", 32'(ms_to_ws_bus[154]), 32'h1);
        chk("ex_alu_pass", ms_to_ws_bus[63:32], 32'h1234_5678);
        chk("ex_no_fwd", 32'(ms_to_ds_bus[38]), 32'h0);
        tick();
        chk("ex_flush_clear", 32'(ms_ex_flush), 32'h0);

        // Reset while in WAIT must not arm DROP.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_load(3'd0, 2'd0, 32'h0);
        tick();
        es_to_ms_valid = 1'b0;
        reset          = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_wait_allowin", 32'(ms_allowin), 32'h1);
        chk("rst_wait_valid", 32'(ms_to_ws_valid), 32'h0);

        // lwr addr_lo=1.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_load(3'd6, 2'd1, 32'haabb_ccdd);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1122_3344;
        #1;
        chk("lwr_valid", 32'(ms_to_ws_valid), 32'h1);
`ifdef MS_UNALIGNED_LD_EN
        chk("lwr_result", ms_to_ws_bus[63:32], 32'haa11_2233);
        chk("lwr_rf_we", 32'(ms_to_ws_bus[72:69]), 32'h7);
`else
        chk("lwr_result", ms_to_ws_bus[63:32], 32'h1122_3344);
        chk("lwr_rf_we", 32'(ms_to_ws_bus[72:69]), 32'hf);
`endif
        chk("lwr_rt_pass", ms_to_ws_bus[105:74], 32'haabb_ccdd);
        chk("lwr_pc_pass", ms_to_ws_bus[31:0], 32'hbfc0_0100);
        tick();
        data_sram_data_ok = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
